vector_mem_responder: RTL and testbench

//  Memory-side responder for the vector load/store unit's word-serial protocol.

---
 rtl/vector_mem_responder.sv | 105 ++++++++++
 tb/tb_vector_mem_responder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/vector_mem_responder.sv
// vector_mem_responder: word RAM responder for scalar and LANES-beat vector bursts with vector read assembly
module vector_mem_responder #(
  parameter int N     = 32,
  parameter int V     = 128,
  parameter int DEPTH = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_wen,
  input  logic         req_vec,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         rsp_valid,
  output logic [N-1:0] rsp_rdata,
  output logic         rsp_err,
  output logic         rsp_last,
  output logic [V-1:0] rsp_vector,
  output logic         rsp_vec_valid,
  output logic         busy
);
  localparam int LANES = V / N;
  localparam int AW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int BW    = LANES > 1 ? $clog2(LANES) : 1;
  typedef enum logic [1:0] {IDLE, VEC, TURN} state_t;
  state_t         state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic           wen_q, wen_d;
  logic [N-1:0]   mem_q [DEPTH];
  logic           acc, cur_wen, cur_vec, last, err, vupd;
  logic [BW-1:0]  lane;
  logic [N-1:0]   rd;
  logic           rsp_valid_q, rsp_err_q, rsp_last_q, rsp_vec_valid_q;
  logic [N-1:0]   rsp_rdata_q;
  logic [V-1:0]   rsp_vector_q, rsp_vector_d;
  // Decode the current beat: in IDLE the beat carries its own kind, inside a burst the latched kind applies
  always_comb begin
    req_ready = state_q != TURN;
    busy      = state_q == VEC;
    acc       = req_valid & req_ready;
    cur_vec   = state_q == IDLE ? req_vec : 1'b1;
    cur_wen   = state_q == IDLE ? req_wen : wen_q;
    lane      = state_q == IDLE ? '0 : beat_q;
    last      = !cur_vec || lane == BW'(LANES - 1);
    err       = req_addr >= N'(DEPTH);
    rd        = (err || cur_wen) ? '0 : mem_q[req_addr[AW-1:0]];
    vupd      = acc & cur_vec & ~cur_wen;
  end
  // Next state: a burst's final lane forces one TURN cycle before new requests
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wen_d   = wen_q;
    if (state_q == TURN) begin
      state_d = IDLE;
    end else if (acc) begin
      wen_d   = cur_wen;
      beat_d  = last ? '0 : lane + BW'(1);
      state_d = last ? (cur_vec ? TURN : IDLE) : VEC;
    end
  end
  // Vector read assembly: lane 0 starts a fresh vector, later lanes drop into their slot
  always_comb begin
    rsp_vector_d = rsp_vector_q;
    for (int k = 0; k < LANES; k++) begin
      if (vupd && int'(lane) == k) rsp_vector_d[k*N +: N] = rd;
      else if (vupd && lane == '0) rsp_vector_d[k*N +: N] = '0;
    end
  end
  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (acc && cur_wen && !err) mem_q[req_addr[AW-1:0]] <= req_wdata;
  end
  // FSM and registered response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      beat_q          <= '0;
      wen_q           <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_err_q       <= 1'b0;
      rsp_last_q      <= 1'b0;
      rsp_vec_valid_q <= 1'b0;
      rsp_rdata_q     <= '0;
      rsp_vector_q    <= '0;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      wen_q           <= wen_d;
      rsp_valid_q     <= acc;
      rsp_err_q       <= acc & err;
      rsp_last_q      <= acc & last;
      rsp_vec_valid_q <= vupd & last;
      rsp_rdata_q     <= acc ? rd : '0;
      rsp_vector_q    <= rsp_vector_d;
    end
  end
  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_last      = rsp_last_q;
  assign rsp_vec_valid = rsp_vec_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_vector    = rsp_vector_q;
endmodule

// File: tb/tb_vector_mem_responder.sv
// tb_vector_mem_responder: directed and random checks of vector_mem_responder against a behavioural model
module tb_vector_mem_responder;
  localparam int N = 32, V = 128, DEPTH = 256, LANES = V / N;
  logic clk = 0, rst = 0, req_valid = 0, req_wen = 0, req_vec = 0;
  logic [N-1:0] req_addr = 0, req_wdata = 0;
  logic req_ready, rsp_valid, rsp_err, rsp_last, rsp_vec_valid, busy;
  logic [N-1:0] rsp_rdata;
  logic [V-1:0] rsp_vector;
  vector_mem_responder #(.N(N), .V(V), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_vec(req_vec), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_last(rsp_last),
    .rsp_vector(rsp_vector), .rsp_vec_valid(rsp_vec_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, pulses = 0;
  logic [N-1:0] mm [DEPTH];
  logic [N-1:0] vm [LANES];
  int left = 0;
  bit turn = 0, bw = 0, e_valid = 0, e_err = 0, e_last = 0, e_vv = 0;
  logic [N-1:0] e_rdata = 0;
  task automatic chk(string nm, logic [V-1:0] got, logic [V-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
    end
  endtask
  // Behavioural model: burst bookkeeping by remaining-beat count, RAM as a plain array
  always @(posedge clk or negedge rst) begin
    bit acc, vec, wen, err;
    int lane;
    logic [N-1:0] d;
    if (!rst) begin
      left = 0; turn = 0; e_valid = 0; e_err = 0; e_last = 0; e_vv = 0; e_rdata = 0;
      foreach (vm[k]) vm[k] = 0;
    end else begin
      acc = req_valid && !turn;
      e_valid = acc; e_err = 0; e_last = 0; e_vv = 0; e_rdata = 0; turn = 0;
      if (acc) begin
        if (left == 0) begin
          vec = req_vec; wen = req_wen; lane = 0;
          if (vec) begin left = LANES - 1; bw = wen; end
        end else begin
          vec = 1; wen = bw; lane = LANES - left; left--;
        end
        err = req_addr >= DEPTH;
        d = (!err && !wen) ? mm[req_addr[7:0]] : 0;
        if (!err && wen) mm[req_addr[7:0]] = req_wdata;
        e_err = err; e_rdata = d;
        e_last = !vec || lane == LANES - 1;
        turn = vec && e_last;
        if (vec && !wen) begin
          if (lane == 0) foreach (vm[k]) vm[k] = 0;
          vm[lane] = d;
          e_vv = e_last;
        end
      end
    end
  end
  // Compare every cycle away from the active edge
  always @(negedge clk) if (rst) begin
    chk("req_ready", req_ready, !turn);
    chk("busy", busy, left > 0);
    chk("rsp_valid", rsp_valid, e_valid);
    chk("rsp_err", rsp_err, e_err);
    chk("rsp_last", rsp_last, e_last);
    chk("rsp_vec_valid", rsp_vec_valid, e_vv);
    if (e_valid) chk("rsp_rdata", rsp_rdata, e_rdata);
    chk("rsp_vector", rsp_vector, {vm[3], vm[2], vm[1], vm[0]});
    if (rsp_valid) pulses++;
  end
  task automatic beat(bit v, bit w, bit vc, logic [N-1:0] a, logic [N-1:0] d);
    req_valid = v; req_wen = w; req_vec = vc; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
  endtask
  task automatic idle();
    beat(0, 0, 0, 0, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vector", rsp_vector, 0);
    rst = 1;
    for (int a = 0; a < DEPTH; a++) beat(1, 1, 0, a, $urandom);
    idle();
    beat(1, 1, 0, 'h10, 32'hDEADBEEF);
    beat(1, 0, 0, 'h10, 0);
    chk("t1_valid", rsp_valid, 1);
    chk("t1_last", rsp_last, 1);
    chk("t1_rdata", rsp_rdata, 32'hDEADBEEF);
    idle();
    for (int i = 0; i < 4; i++) beat(1, 1, 1, 4 + i, i + 1);
    chk("t2_turn_w", req_ready, 0);
    idle();
    for (int i = 0; i < 4; i++) beat(1, 0, 1, 4 + i, 0);
    chk("t2_vv", rsp_vec_valid, 1);
    chk("t2_vector", rsp_vector, 128'h00000004_00000003_00000002_00000001);
    chk("t2_turn_r", req_ready, 0);
    idle();
    beat(1, 1, 0, 44, 32'h12345678);
    beat(1, 0, 0, 300, 0);
    chk("t3_err", rsp_err, 1);
    chk("t3_rdata", rsp_rdata, 0);
    beat(1, 1, 0, 300, 32'hFFFFFFFF);
    chk("t3_werr", rsp_err, 1);
    beat(1, 0, 0, 44, 0);
    chk("t3_alias", rsp_rdata, 32'h12345678);
    idle();
    pulses = 0;
    beat(1, 0, 1, 4, 0);
    beat(1, 0, 1, 5, 0);
    repeat (3) begin
      idle();
      chk("t4_busy", busy, 1);
    end
    beat(1, 0, 1, 6, 0);
    beat(1, 0, 1, 7, 0);
    chk("t4_last", rsp_last, 1);
    idle();
    chk("t4_pulses", pulses, 4);
    chk("t4_vector", rsp_vector, 128'h00000004_00000003_00000002_00000001);
    beat(1, 1, 1, 8, 32'hAAAA0001);
    beat(1, 1, 1, 9, 32'hAAAA0002);
    rst = 0;
    #1;
    chk("t5_valid", rsp_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", req_ready, 1);
    chk("t5_vector", rsp_vector, 0);
    rst = 1;
    beat(1, 0, 0, 8, 0);
    chk("t5_rdata", rsp_rdata, 32'hAAAA0001);
    idle();
    beat(1, 0, 1, 4, 0);
    beat(1, 1, 0, 5, 32'hFFFF);
    beat(1, 1, 0, 6, 32'hFFFF);
    beat(1, 1, 0, 7, 32'hFFFF);
    chk("t6_vv", rsp_vec_valid, 1);
    chk("t6_vector", rsp_vector, 128'h00000004_00000003_00000002_00000001);
    idle();
    beat(1, 0, 0, 5, 0);
    chk("t6_rdata", rsp_rdata, 2);
    repeat (3000) begin
      beat($urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0 ? $urandom : ($urandom_range(0, 1) == 1 ? $urandom_range(0, 15) : $urandom_range(0, DEPTH - 1)),
           $urandom);
    end
    repeat (3) idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
